// File: rtl/sevseg_pkg.sv
// Segment patterns (a..g at bits 6..0, active high) and nibble decode helpers.
// Hex letters are only used by the decoder when SEVSEG_HEX_EN is defined.
package sevseg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_0 = 7'h7E;
    localparam logic [6:0] SEG_1 = 7'h30;
    localparam logic [6:0] SEG_2 = 7'h6D;
    localparam logic [6:0] SEG_3 = 7'h79;
    localparam logic [6:0] SEG_4 = 7'h33;
    localparam logic [6:0] SEG_5 = 7'h5B;
    localparam logic [6:0] SEG_6 = 7'h5F;
    localparam logic [6:0] SEG_7 = 7'h70;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h7B;
    localparam logic [6:0] SEG_A = 7'h77;
    localparam logic [6:0] SEG_B = 7'h1F;
    localparam logic [6:0] SEG_C = 7'h4E;
    localparam logic [6:0] SEG_D = 7'h3D;
    localparam logic [6:0] SEG_E = 7'h4F;
    localparam logic [6:0] SEG_F = 7'h47;

    function automatic logic [6:0] decDigit(input logic [3:0] n);
        case (n)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

    function automatic logic [6:0] decHex(input logic [3:0] n);
        case (n)
            4'hA:    return SEG_A;
            4'hB:    return SEG_B;
            4'hC:    return SEG_C;
            4'hD:    return SEG_D;
            4'hE:    return SEG_E;
            4'hF:    return SEG_F;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// Nibble to active-high segment pattern.
// SEVSEG_HEX_EN enables A..F glyphs; otherwise they decode blank.
module seven_seg_decoder
    import sevseg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] segments
);

    always_comb begin
        segments = decDigit(nibble);
`ifdef SEVSEG_HEX_EN
        if (nibble > 4'd9) segments = decHex(nibble);
`else
        if (nibble > 4'd9) segments = SEG_BLANK;
`endif
    end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Multiplexed seven-segment scanner with shadow/active buffering and LZS.
// Hex glyphs A..F follow the SEVSEG_HEX_EN build macro (see decoder).
module seven_seg_scan_driver
    import sevseg_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int PRESCALE       = 50000,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int DIG_ACTIVE_LOW = 0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] io_valueIn,
    input  logic [NUM_DIGITS-1:0]   io_dpIn,
    input  logic [NUM_DIGITS-1:0]   io_blankIn,
    input  logic                    io_lzsEn,
    input  logic                    io_load,
    output logic [6:0]              io_segOut,
    output logic                    io_dpOut,
    output logic [NUM_DIGITS-1:0]   io_digitSel,
    output logic                    io_frameDone
);

    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
    localparam logic DIG_INV = (DIG_ACTIVE_LOW != 0);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
    localparam logic [PW-1:0] LAST_CNT = PW'(PRESCALE - 1);

    logic [PW-1:0] cnt;
    logic [IW-1:0] idx;
    logic          tc;
    logic          wrap;

    logic [4*NUM_DIGITS-1:0] shVal, actVal;
    logic [NUM_DIGITS-1:0]   shDp, actDp;
    logic [NUM_DIGITS-1:0]   shBlank, actBlank;
    logic                    shLzs, actLzs;

    logic [3:0]            selNib;
    logic                  selDp;
    logic                  selBlank;
    logic                  upperZero;
    logic                  dark;
    logic [NUM_DIGITS-1:0] selOneHot;
    logic [6:0]            decSeg;

    assign tc   = (cnt == LAST_CNT);
    assign wrap = tc && (idx == LAST_IDX);

    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            cnt <= tc ? '0 : cnt + 1'b1;
            if (tc) idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
        end
    end

    // A load coinciding with the wrap bypasses the shadow into the new frame.
    always_ff @(posedge clock) begin
        if (!reset) begin
            shVal    <= '0;
            shDp     <= '0;
            shBlank  <= '1;
            shLzs    <= 1'b0;
            actVal   <= '0;
            actDp    <= '0;
            actBlank <= '1;
            actLzs   <= 1'b0;
        end else begin
            if (io_load) begin
                shVal   <= io_valueIn;
                shDp    <= io_dpIn;
                shBlank <= io_blankIn;
                shLzs   <= io_lzsEn;
            end
            if (wrap) begin
                actVal   <= io_load ? io_valueIn : shVal;
                actDp    <= io_load ? io_dpIn    : shDp;
                actBlank <= io_load ? io_blankIn : shBlank;
                actLzs   <= io_load ? io_lzsEn   : shLzs;
            end
        end
    end

    always_comb begin
        selNib    = 4'h0;
        selDp     = 1'b0;
        selBlank  = 1'b0;
        upperZero = 1'b1;
        selOneHot = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (IW'(k) == idx) begin
                selNib       = actVal[4*k +: 4];
                selDp        = actDp[k];
                selBlank     = actBlank[k];
                selOneHot[k] = 1'b1;
            end
            if (IW'(k) >= idx && actVal[4*k +: 4] != 4'h0) upperZero = 1'b0;
        end
        dark = selBlank || (actLzs && idx != '0 && upperZero);
    end

    seven_seg_decoder u_dec (
        .nibble   (selNib),
        .segments (decSeg)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            io_segOut    <= {7{SEG_INV}};
            io_dpOut     <= SEG_INV;
            io_digitSel  <= {NUM_DIGITS{DIG_INV}};
            io_frameDone <= 1'b0;
        end else begin
            io_segOut    <= (dark ? SEG_BLANK : decSeg) ^ {7{SEG_INV}};
            io_dpOut     <= (dark ? 1'b0 : selDp) ^ SEG_INV;
            io_digitSel  <= selOneHot ^ {NUM_DIGITS{DIG_INV}};
            io_frameDone <= wrap;
        end
    end

endmodule
